// File: rtl/key_cmd_scheduler.sv
// key_cmd_scheduler
// Maps keyboard ASCII strobes to game command codes. Each command passes a
// mode gate and a same-key repeat lockout. Surviving commands are queued in a
// small FIFO and handed to the game FSM over a valid/ready handshake.
//
// Ports:
//   clock       system clock
//   reset       synchronous, active-high reset; flushes the queue
//   key_ascii   ASCII byte from the receiver, sampled when key_strobe=1
//   key_strobe  one-cycle pulse marking a new key press
//   game_active 1 = in play, 0 = title/pause (only START/PAUSE pass)
//   cmd_data    command code at the FIFO head
//   cmd_valid   FIFO not empty
//   cmd_ready   consumer takes the head this cycle
//   fifo_count  occupied entries, 0..DEPTH
//   overflow    sticky: a command was dropped on a full FIFO
//   ovf_clr     clears overflow (a same-cycle drop wins)
module key_cmd_scheduler #(
  parameter int unsigned LOCK_CYCLES = 2500000,
  parameter int unsigned LOCK_W      = 22,
  parameter int unsigned DEPTH       = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] key_ascii,
  input  logic       key_strobe,
  input  logic       game_active,
  output logic [2:0] cmd_data,
  output logic       cmd_valid,
  input  logic       cmd_ready,
  output logic [2:0] fifo_count,
  output logic       overflow,
  input  logic       ovf_clr
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CMD_W = 3;

  typedef enum logic {IDLE, LOCK} lock_state_t;

  lock_state_t       state;
  logic [CMD_W-1:0]  last_cmd;
  logic [LOCK_W-1:0] lock_cnt;
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  wr_ptr;
  logic [CMD_W-1:0]  mem [DEPTH];

  logic [CMD_W-1:0]  code_c;
  logic              pass_c;
  logic              cand_c;
  logic              pop_c;
  logic              full_c;
  logic              push_c;
  logic              drop_c;
  logic [PTR_W-1:0]  rd_n_c;
  logic [2:0]        count_n_c;
  logic [CMD_W-1:0]  head_n_c;

  // ASCII to command code; 0 means "not a command"
  always_comb begin
    code_c = 3'd0;
    case (key_ascii)
      8'h41:   code_c = 3'd1;
      8'h44:   code_c = 3'd2;
      8'h57:   code_c = 3'd3;
      8'h53:   code_c = 3'd4;
      8'h4A:   code_c = 3'd5;
      8'h13:   code_c = 3'd6;
      8'h27:   code_c = 3'd7;
      default: code_c = 3'd0;
    endcase
  end

  // Filtering, push/pop decisions and the next FIFO head
  always_comb begin
    pass_c    = (code_c != 3'd0) && (game_active || (code_c >= 3'd6));
    cand_c    = key_strobe && pass_c && !((state == LOCK) && (code_c == last_cmd));
    pop_c     = cmd_valid && cmd_ready;
    full_c    = (fifo_count == 3'(DEPTH));
    // A same-cycle pop frees a slot for the incoming command
    push_c    = cand_c && (!full_c || pop_c);
    drop_c    = cand_c && full_c && !pop_c;
    rd_n_c    = pop_c ? (rd_ptr + PTR_W'(1)) : rd_ptr;
    count_n_c = fifo_count + 3'(push_c) - 3'(pop_c);
    // The new head may be the entry written on this very edge
    head_n_c  = (push_c && (wr_ptr == rd_n_c)) ? code_c : mem[rd_n_c];
  end

  // FIFO storage; contents need no reset since count gates visibility
  always_ff @(posedge clock) begin
    if (push_c) begin
      mem[wr_ptr] <= code_c;
    end
  end

  // Pointers, registered outputs and the lockout FSM
  always_ff @(posedge clock) begin
    if (reset) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      fifo_count <= '0;
      cmd_valid  <= 1'b0;
      cmd_data   <= '0;
      overflow   <= 1'b0;
      state      <= IDLE;
      last_cmd   <= '0;
      lock_cnt   <= '0;
    end else begin
      if (push_c) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      rd_ptr     <= rd_n_c;
      fifo_count <= count_n_c;
      cmd_valid  <= (count_n_c != 3'd0);
      cmd_data   <= head_n_c;

      if (drop_c) begin
        overflow <= 1'b1;
      end else if (ovf_clr) begin
        overflow <= 1'b0;
      end

      // Only real pushes arm the lockout; drops and rejected repeats do not
      case (state)
        IDLE: begin
          if (push_c) begin
            last_cmd <= code_c;
            lock_cnt <= LOCK_W'(LOCK_CYCLES - 1);
            state    <= LOCK;
          end
        end
        LOCK: begin
          if (push_c) begin
            last_cmd <= code_c;
            lock_cnt <= LOCK_W'(LOCK_CYCLES - 1);
          end else if (lock_cnt == '0) begin
            state <= IDLE;
          end else begin
            lock_cnt <= lock_cnt - LOCK_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
